// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: steers the registered 4:1 TX mux through
// start, LSB-first data, optional parity and stop bits, one bit per CLK.
//
// state  | meaning
// IDLE   | line idle (mux=01), waiting for Data_Valid
// START  | start bit (mux=00)
// DATA   | payload bit data_reg[bit_cnt] (mux=10)
// PARITY | parity bit (mux=11)
// STOP   | stop bit (mux=01); may accept the next frame directly
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_reg_q, data_reg_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic [1:0]              mux_sel_q, mux_sel_d;
  logic                    ser_data_q, ser_data_d;
  logic                    busy_q, busy_d;
  logic                    accept;

  assign accept = ((state_q == IDLE) || (state_q == STOP)) && Data_Valid;

  always_comb begin
    state_d    = state_q;
    data_reg_d = data_reg_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;

    case (state_q)
      START:   state_d = DATA;
      DATA: begin
        // bit_cnt saturates on the last payload bit rather than wrapping
        if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
        else                       bit_cnt_d = bit_cnt_q + 1'b1;
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d    = START;
      data_reg_d = P_DATA;
      par_en_d   = PAR_EN;
      par_bit_d  = (^P_DATA) ^ PAR_TYP;
      bit_cnt_d  = '0;
    end

    // outputs decoded from the next state so they are flops yet line up with state_q
    case (state_d)
      START:   mux_sel_d = 2'b00;
      DATA:    mux_sel_d = 2'b10;
      PARITY:  mux_sel_d = 2'b11;
      default: mux_sel_d = 2'b01;
    endcase
    busy_d     = (state_d != IDLE);
    ser_data_d = (state_d == DATA) ? data_reg_d[bit_cnt_d] : 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      data_reg_q <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      mux_sel_q  <= 2'b01;
      ser_data_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_reg_q <= data_reg_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      mux_sel_q  <= mux_sel_d;
      ser_data_q <= ser_data_d;
      busy_q     <= busy_d;
    end
  end

  assign mux_sel  = mux_sel_q;
  assign ser_data = ser_data_q;
  assign par_bit  = par_bit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: reset, 8N1/8E1/8O1 frames, back-to-back
// frames, mid-frame input activity and mid-frame reset.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [1:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sel"},  {6'd0, mux_sel}, 8'h01);
    chk({tag, "_busy"}, {7'd0, busy},    8'h00);
    chk({tag, "_ser"},  {7'd0, ser_data}, 8'h00);
  endtask

  // Called at #1 after the acceptance edge; ends in the STOP cycle.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                           input logic exp_par, input int exp_len, input logic disturb);
    int busy_cyc = 0;
    chk({tag, "_start_sel"},  {6'd0, mux_sel},  8'h00);
    chk({tag, "_start_busy"}, {7'd0, busy},     8'h01);
    chk({tag, "_start_ser"},  {7'd0, ser_data}, 8'h00);
    chk({tag, "_par_bit"},    {7'd0, par_bit},  {7'd0, exp_par});
    if (busy) busy_cyc++;
    for (int i = 0; i < 8; i++) begin
      if (disturb && i == 3) begin
        P_DATA     = 8'hFF;
        Data_Valid = 1'b1;
      end
      if (disturb && i == 4) Data_Valid = 1'b0;
      tick;
      if (busy) busy_cyc++;
      chk($sformatf("%s_d%0d_sel", tag, i), {6'd0, mux_sel},  8'h02);
      chk($sformatf("%s_d%0d_ser", tag, i), {7'd0, ser_data}, {7'd0, d[i]});
    end
    if (pe) begin
      tick;
      if (busy) busy_cyc++;
      chk({tag, "_par_sel"}, {6'd0, mux_sel}, 8'h03);
      chk({tag, "_par_val"}, {7'd0, par_bit}, {7'd0, exp_par});
    end
    tick;
    if (busy) busy_cyc++;
    chk({tag, "_stop_sel"},  {6'd0, mux_sel}, 8'h01);
    chk({tag, "_stop_busy"}, {7'd0, busy},    8'h01);
    chk({tag, "_busy_len"},  8'(busy_cyc),    8'(exp_len));
  endtask

  initial begin
    // reset held with Data_Valid high: no frame may start
    RST = 1'b0; Data_Valid = 1'b1; P_DATA = 8'hA5;
    tick; tick;
    chk_idle("rst");
    chk("rst_par", {7'd0, par_bit}, 8'h00);
    Data_Valid = 1'b0; RST = 1'b1;
    tick; tick;
    chk_idle("rst_rel");

    // 8N1, A5 = 1010_0101 -> LSB first 1,0,1,0,0,1,0,1; even parity reg = 0
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    tick;
    Data_Valid = 1'b0;
    run_frame("n81", 8'hA5, 1'b0, 1'b0, 10, 1'b0);
    tick;
    chk_idle("n81_after");

    // 8E1 A5: four ones -> parity 0
    PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    tick;
    Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b1;
    run_frame("e81", 8'hA5, 1'b1, 1'b0, 11, 1'b0);
    tick;
    chk_idle("e81_after");

    // 8O1 A5 -> parity 1, held after the frame
    PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    tick;
    Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    run_frame("o81", 8'hA5, 1'b1, 1'b1, 11, 1'b0);
    tick;
    chk_idle("o81_after");
    chk("o81_par_hold", {7'd0, par_bit}, 8'h01);

    // back-to-back 3C then 81 with Data_Valid held high
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    tick;
    P_DATA = 8'h81;
    run_frame("b2b0", 8'h3C, 1'b0, 1'b0, 10, 1'b0);
    tick;
    Data_Valid = 1'b0;
    run_frame("b2b1", 8'h81, 1'b0, 1'b0, 10, 1'b0);
    tick;
    chk_idle("b2b_after");

    // mid-frame P_DATA change and Data_Valid pulse are ignored
    P_DATA = 8'h5A; Data_Valid = 1'b1;
    tick;
    Data_Valid = 1'b0;
    run_frame("mid", 8'h5A, 1'b0, 1'b0, 10, 1'b1);
    tick;
    chk_idle("mid_after");
    tick;
    chk_idle("mid_after2");

    // reset in the 4th data bit of an odd-parity frame
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    tick;
    Data_Valid = 1'b0;
    chk("rmid_par_pre", {7'd0, par_bit}, 8'h01);
    tick; tick; tick; tick;
    chk("rmid_d3_sel", {6'd0, mux_sel}, 8'h02);
    RST = 1'b0;
    tick;
    chk_idle("rmid");
    chk("rmid_par", {7'd0, par_bit}, 8'h00);
    RST = 1'b1;
    tick;
    chk_idle("rmid_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
